// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write arbiter:
//   - register-file geometry (address/data width, register count)
//   - arbiter FSM state encoding
//   - write-request record (destination address + data)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 16;
    localparam int NUM_REGS   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// -----------------------------------------------------------------------------
// regfile_wr_fifo
// Per-requester write FIFO. Pointers carry one extra wrap bit so full/empty
// are distinguished without a separate counter. Also exports every slot's
// address together with an occupied flag so the top level can run the
// read-after-write hazard compare against all queued writes.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (empties the FIFO)
//   push_i           push request; ignored while full (no pop bypass)
//   push_addr_i/_data_i  entry written on push
//   pop_i            pop request; ignored while empty
//   head_addr_o/_data_o  oldest entry (valid only when !empty_o)
//   full_o, empty_o  registered-state status flags
//   occ_addr_o       address stored in each physical slot
//   occ_vld_o        slot currently holds a queued entry
// -----------------------------------------------------------------------------
module regfile_wr_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [ADDR_W-1:0]            push_addr_i,
    input  logic [DATA_W-1:0]            push_data_i,
    input  logic                         pop_i,
    output logic [ADDR_W-1:0]            head_addr_o,
    output logic [DATA_W-1:0]            head_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] occ_addr_o,
    output logic [DEPTH-1:0]             occ_vld_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count;
    logic              do_push, do_pop;
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    // Wrap bits differ with equal index bits -> writer is a full lap ahead.
    assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: occupancy is derived from the pointers only.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem_q[wr_ptr_q[IDX_W-1:0]] <= push_addr_i;
            data_mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
        end
    end

    assign head_addr_o = addr_mem_q[rd_ptr_q[IDX_W-1:0]];
    assign head_data_o = data_mem_q[rd_ptr_q[IDX_W-1:0]];

    assign count = wr_ptr_q - rd_ptr_q;

    // A slot is occupied when its distance from the read index is below
    // the current fill count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_occ
        logic [IDX_W-1:0] offs;
        assign offs          = IDX_W'(g) - rd_ptr_q[IDX_W-1:0];
        assign occ_vld_o[g]  = ({1'b0, offs} < count);
        assign occ_addr_o[g] = addr_mem_q[g];
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port between requester 0 (pipeline
// writeback) and requester 1 (load/debug unit). Each requester is buffered
// in its own FIFO; in IDLE a round-robin choice picks the next write, which
// is driven as a WR_PULSE-cycle rf_we pulse followed by one settle cycle
// during which rd_valid stays low so the read outputs can refresh.
//
// Handshake: a request is accepted on a rising edge where reqN_valid and
// reqN_ready are both high; reqN_ready reflects only registered FIFO state
// (no same-cycle pop bypass) and valid need not be held after acceptance.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   reqN_valid/_addr/_data   write request from requester N
//   reqN_ready               requester N FIFO not full
//   rd_addr1, rd_addr2       decode read addresses, used for hazard compare
//   rf_we/rf_waddr/rf_wdata  register-file write controls
//   rd_valid                 register-file read outputs are stable
//   raw_hz1, raw_hz2         read address has a queued or in-flight write
//   grant_id                 requester owning the current/last write
//   dbg_state                current arbiter state (observability)
// -----------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W     = REG_DATA_W,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int FIFO_DEPTH = 2,
    parameter int WR_PULSE   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rd_valid,
    output logic              raw_hz1,
    output logic              raw_hz2,
    output logic              grant_id,
    output arb_state_e        dbg_state
);

    localparam int CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_q, grant_d;
    logic              rr_q, rr_d;      // 1: favour requester 1 on contention
    logic              win1;
    logic              pop0, pop1;

    logic                              full0, empty0, full1, empty1;
    logic [ADDR_W-1:0]                 head0_addr, head1_addr;
    logic [DATA_W-1:0]                 head0_data, head1_data;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] occ0_addr, occ1_addr;
    logic [FIFO_DEPTH-1:0]             occ0_vld, occ1_vld;

    regfile_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fifo0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (req0_valid),
        .push_addr_i(req0_addr),
        .push_data_i(req0_data),
        .pop_i      (pop0),
        .head_addr_o(head0_addr),
        .head_data_o(head0_data),
        .full_o     (full0),
        .empty_o    (empty0),
        .occ_addr_o (occ0_addr),
        .occ_vld_o  (occ0_vld)
    );

    regfile_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fifo1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (req1_valid),
        .push_addr_i(req1_addr),
        .push_data_i(req1_data),
        .pop_i      (pop1),
        .head_addr_o(head1_addr),
        .head_data_o(head1_data),
        .full_o     (full1),
        .empty_o    (empty1),
        .occ_addr_o (occ1_addr),
        .occ_vld_o  (occ1_vld)
    );

    assign req0_ready = !full0;
    assign req1_ready = !full1;

    // State register (also holds the registered write controls).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            grant_q <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    // Next-state logic; arbitration happens only while IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        win1    = 1'b0;
        pop0    = 1'b0;
        pop1    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty0 || !empty1) begin
                    // A lone non-empty FIFO wins outright; otherwise rr_q decides.
                    win1    = empty0 ? 1'b1 : (empty1 ? 1'b0 : rr_q);
                    pop0    = !win1;
                    pop1    = win1;
                    waddr_d = win1 ? head1_addr : head0_addr;
                    wdata_d = win1 ? head1_data : head0_data;
                    grant_d = win1;
                    rr_d    = !win1;
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (cnt_q == CNT_W'(WR_PULSE - 1)) begin
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. rf_we is decoded from state so reset drops it at once.
    always_comb begin
        rf_we    = (state_q == WRITE);
        rd_valid = (state_q == IDLE);
    end

    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign grant_id  = grant_q;
    assign dbg_state = state_q;

    // Hazard: any queued entry in either FIFO, or the write being driven.
    always_comb begin
        raw_hz1 = 1'b0;
        raw_hz2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (occ0_vld[i] && (occ0_addr[i] == rd_addr1)) raw_hz1 = 1'b1;
            if (occ1_vld[i] && (occ1_addr[i] == rd_addr1)) raw_hz1 = 1'b1;
            if (occ0_vld[i] && (occ0_addr[i] == rd_addr2)) raw_hz2 = 1'b1;
            if (occ1_vld[i] && (occ1_addr[i] == rd_addr2)) raw_hz2 = 1'b1;
        end
        if ((state_q != IDLE) && (waddr_q == rd_addr1)) raw_hz1 = 1'b1;
        if ((state_q != IDLE) && (waddr_q == rd_addr2)) raw_hz2 = 1'b1;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Bench for regfile_write_arbiter. The main instance uses WR_PULSE=1; a second
// instance sharing the same inputs uses WR_PULSE=3 for the long-pulse case.
// Expected commits {grant_id, rf_waddr, rf_wdata} are queued when requests are
// driven and popped at each rising edge of rf_we on the main instance.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int AW = 3;
    localparam int DW = 16;
    localparam int EW = 1 + AW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr, rd_addr1, rd_addr2;
    logic [DW-1:0] req0_data, req1_data;

    logic          req0_ready, req1_ready, rf_we, rd_valid, raw_hz1, raw_hz2, grant_id;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    arb_state_e    dbg_state;

    logic          req0_ready_p3, req1_ready_p3, rf_we_p3, rd_valid_p3;
    logic          raw_hz1_p3, raw_hz2_p3, grant_id_p3;
    logic [AW-1:0] rf_waddr_p3;
    logic [DW-1:0] rf_wdata_p3;
    arb_state_e    dbg_state_p3;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2), .WR_PULSE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rd_valid(rd_valid),
        .raw_hz1(raw_hz1), .raw_hz2(raw_hz2), .grant_id(grant_id), .dbg_state(dbg_state)
    );

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2), .WR_PULSE(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready_p3),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready_p3),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rf_we(rf_we_p3), .rf_waddr(rf_waddr_p3), .rf_wdata(rf_wdata_p3), .rd_valid(rd_valid_p3),
        .raw_hz1(raw_hz1_p3), .raw_hz2(raw_hz2_p3), .grant_id(grant_id_p3), .dbg_state(dbg_state_p3)
    );

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic          we_prev = 1'b0;

    always @(negedge clk) begin
        logic [EW-1:0] exp_item;
        if (rst_n) begin
            if (rf_we && !we_prev) begin
                check_eq("sb_pending", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_item = exp_q.pop_front();
                    check_eq("commit", {grant_id, rf_waddr, rf_wdata}, exp_item);
                end
            end
            we_prev = rf_we;
        end else begin
            we_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int r, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (r == 0) begin
            req0_valid = v; req0_addr = a; req0_data = d;
        end else begin
            req1_valid = v; req1_addr = a; req1_data = d;
        end
    endtask

    task automatic exp_push(input logic g, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({g, a, d});
    endtask

    // Leaves the bench 1 time unit after "edge 0" with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        #1;
        check_eq("rst_we", rf_we, 0);
        check_eq("rst_waddr", rf_waddr, 0);
        check_eq("rst_wdata", rf_wdata, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_rdy0", req0_ready, 1);
        check_eq("rst_rdy1", req1_ready, 1);
        check_eq("rst_rdv", rd_valid, 1);
        check_eq("rst_we_p3", rf_we_p3, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq("drain", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1;
        rd_addr1 = '0;
        rd_addr2 = '0;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        #2;

        // Single write: push at edge 1, rf_we in cycle 2, settle cycle 3.
        do_reset();
        rd_addr1 = 3'd7; rd_addr2 = 3'd7;
        set_req(0, 1'b1, 3'd3, 16'h0045);
        exp_push(1'b0, 3'd3, 16'h0045);
        @(posedge clk); #1 set_req(0, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("s1_c1_we", rf_we, 0);
        check_eq("s1_c1_rdv", rd_valid, 1);
        @(negedge clk);
        check_eq("s1_c2_we", rf_we, 1);
        check_eq("s1_c2_waddr", rf_waddr, 3);
        check_eq("s1_c2_wdata", rf_wdata, 16'h0045);
        check_eq("s1_c2_rdv", rd_valid, 0);
        @(negedge clk);
        check_eq("s1_c3_we", rf_we, 0);
        check_eq("s1_c3_rdv", rd_valid, 0);
        check_eq("s1_c3_waddr", rf_waddr, 3);
        @(negedge clk);
        check_eq("s1_c4_rdv", rd_valid, 1);
        check_eq("s1_c4_we", rf_we, 0);
        wait_drain();

        // Contention: pair at edge 1, second pair at edge 2.
        do_reset();
        exp_push(1'b0, 3'd1, 16'h000E);
        exp_push(1'b1, 3'd2, 16'h0004);
        exp_push(1'b0, 3'd4, 16'h000A);
        exp_push(1'b1, 3'd5, 16'h000B);
        set_req(0, 1'b1, 3'd1, 16'h000E);
        set_req(1, 1'b1, 3'd2, 16'h0004);
        @(posedge clk); #1;
        set_req(0, 1'b1, 3'd4, 16'h000A);
        set_req(1, 1'b1, 3'd5, 16'h000B);
        @(posedge clk); #1;
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("s2_c2_grant", grant_id, 0);
        check_eq("s2_c2_waddr", rf_waddr, 1);
        check_eq("s2_c2_rdy0", req0_ready, 1);
        check_eq("s2_c2_rdy1", req1_ready, 0);
        repeat (2) @(negedge clk);
        check_eq("s2_c4_rdv", rd_valid, 1);
        @(negedge clk);
        check_eq("s2_c5_we", rf_we, 1);
        check_eq("s2_c5_grant", grant_id, 1);
        check_eq("s2_c5_waddr", rf_waddr, 2);
        check_eq("s2_c5_rdy1", req1_ready, 1);
        repeat (3) @(negedge clk);
        check_eq("s2_c8_grant", grant_id, 0);
        check_eq("s2_c8_waddr", rf_waddr, 4);
        repeat (3) @(negedge clk);
        check_eq("s2_c11_grant", grant_id, 1);
        check_eq("s2_c11_waddr", rf_waddr, 5);
        wait_drain();

        // Backpressure: req1 occupies the port while req0 fills its FIFO.
        do_reset();
        exp_push(1'b1, 3'd0, 16'h0999);
        exp_push(1'b0, 3'd6, 16'h0111);
        exp_push(1'b0, 3'd7, 16'h0222);
        exp_push(1'b0, 3'd0, 16'h0333);
        set_req(1, 1'b1, 3'd0, 16'h0999);
        @(posedge clk); #1;
        set_req(1, 1'b0, '0, '0);
        set_req(0, 1'b1, 3'd6, 16'h0111);
        @(posedge clk); #1;
        set_req(0, 1'b1, 3'd7, 16'h0222);
        @(negedge clk);
        check_eq("s3_c2_rdy0", req0_ready, 1);
        check_eq("s3_c2_grant", grant_id, 1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 3'd0, 16'h0333);
        @(negedge clk);
        check_eq("s3_c3_rdy0", req0_ready, 0);
        @(negedge clk);
        check_eq("s3_c4_rdy0", req0_ready, 0);
        @(negedge clk);
        check_eq("s3_c5_rdy0", req0_ready, 1);
        check_eq("s3_c5_we", rf_we, 1);
        check_eq("s3_c5_waddr", rf_waddr, 6);
        @(posedge clk); #1 set_req(0, 1'b0, '0, '0);
        wait_drain();

        // Hazard: write to r5 visible from push until SETTLE->IDLE.
        do_reset();
        rd_addr1 = 3'd5; rd_addr2 = 3'd6;
        @(negedge clk);
        check_eq("s4_c0_hz1", raw_hz1, 0);
        set_req(0, 1'b1, 3'd5, 16'h0055);
        exp_push(1'b0, 3'd5, 16'h0055);
        @(posedge clk); #1 set_req(0, 1'b0, '0, '0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_eq("s4_hz1", raw_hz1, 1);
            check_eq("s4_hz2", raw_hz2, 0);
        end
        @(negedge clk);
        check_eq("s4_c4_hz1", raw_hz1, 0);
        check_eq("s4_c4_hz2", raw_hz2, 0);
        wait_drain();

        // Reset mid-write with one entry still queued.
        do_reset();
        rd_addr1 = 3'd3; rd_addr2 = 3'd2;
        exp_push(1'b0, 3'd2, 16'h0AAA);
        set_req(0, 1'b1, 3'd2, 16'h0AAA);
        @(posedge clk); #1 set_req(0, 1'b1, 3'd3, 16'h0BBB);
        @(posedge clk); #1 set_req(0, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("s5_c2_we", rf_we, 1);
        check_eq("s5_c2_hz1", raw_hz1, 1);
        check_eq("s5_c2_hz2", raw_hz2, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("s5_rst_we", rf_we, 0);
        check_eq("s5_rst_rdy0", req0_ready, 1);
        check_eq("s5_rst_rdy1", req1_ready, 1);
        check_eq("s5_rst_rdv", rd_valid, 1);
        check_eq("s5_rst_hz1", raw_hz1, 0);
        check_eq("s5_rst_hz2", raw_hz2, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check_eq("s5_no_wr", rf_we, 0);
        end
        check_eq("s5_sb_empty", exp_q.size(), 0);

        // WR_PULSE=3 instance: three-cycle pulse, one settle cycle, IDLE.
        do_reset();
        exp_push(1'b0, 3'd4, 16'h0C0C);
        set_req(0, 1'b1, 3'd4, 16'h0C0C);
        @(posedge clk); #1 set_req(0, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("s6_c1_we", rf_we_p3, 0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            check_eq("s6_we", rf_we_p3, 1);
            check_eq("s6_waddr", rf_waddr_p3, 4);
            check_eq("s6_wdata", rf_wdata_p3, 16'h0C0C);
            check_eq("s6_rdv", rd_valid_p3, 0);
        end
        @(negedge clk);
        check_eq("s6_c5_we", rf_we_p3, 0);
        check_eq("s6_c5_rdv", rd_valid_p3, 0);
        @(negedge clk);
        check_eq("s6_c6_we", rf_we_p3, 0);
        check_eq("s6_c6_rdv", rd_valid_p3, 1);
        wait_drain();

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
